// File: rtl/m_uart_tx.sv
// m_uart_tx: Wishbone UART transmitter (8N1, LSB first) fed by a byte FIFO,
// with a pollable STATUS register and a sticky overflow flag.
module m_uart_tx #(
  parameter int CLKDIV = 286,
  parameter int FIFOLOG2 = 3
) (
  input  logic       CLK_I,
  input  logic       RST_I,
  input  logic       STB_I,
  input  logic       WE_I,
  input  logic       ADR_I,
  input  logic [7:0] DAT_I,
  output logic       ACK_O,
  output logic [7:0] DAT_O,
  output logic       txd
);
  localparam int DEPTH = 1 << FIFOLOG2;
  localparam logic [15:0] BT_MAX = 16'(CLKDIV - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state;
  logic [7:0] mem [DEPTH];
  logic [FIFOLOG2-1:0] rp, wp;
  logic [FIFOLOG2:0] count;
  logic ovf;
  logic [15:0] bt;
  logic [2:0] bi;
  logic [7:0] sh;
  logic empty, full, pop, push_req, push, clr;
  logic [31:0] cnt_w;
  logic [3:0] cnt_f;
  assign empty = count == '0;
  assign full = count[FIFOLOG2];
  assign pop = !empty && (state == IDLE || (state == STOP && bt == '0));
  assign push_req = STB_I && WE_I && !ADR_I;
  // a full FIFO still accepts a push on the edge that frees a slot
  assign push = push_req && (!full || pop);
  assign clr = STB_I && WE_I && ADR_I && DAT_I[0];
  assign cnt_w = 32'(count);
  assign cnt_f = cnt_w > 32'd15 ? 4'd15 : cnt_w[3:0];
  assign ACK_O = STB_I;
  assign DAT_O = (STB_I && !WE_I && !ADR_I) ? {cnt_f, ovf, state != IDLE, full, empty} : 8'h00;
  always_ff @(posedge CLK_I)
    if (push) mem[wp] <= DAT_I;
  always_ff @(posedge CLK_I or posedge RST_I)
    if (RST_I) begin
      rp <= '0;
      wp <= '0;
      count <= '0;
      ovf <= 1'b0;
    end else begin
      if (push) wp <= wp + FIFOLOG2'(1);
      if (pop) rp <= rp + FIFOLOG2'(1);
      count <= count + (FIFOLOG2+1)'(push) - (FIFOLOG2+1)'(pop);
      ovf <= clr ? 1'b0 : (push_req && !push) ? 1'b1 : ovf;
    end
  always_ff @(posedge CLK_I or posedge RST_I)
    if (RST_I) begin
      state <= IDLE;
      bt <= '0;
      bi <= '0;
      sh <= '0;
      txd <= 1'b1;
    end else begin
      case (state)
        IDLE:
          if (pop) begin
            sh <= mem[rp];
            txd <= 1'b0;
            bt <= BT_MAX;
            state <= START;
          end else txd <= 1'b1;
        START:
          if (bt != '0) bt <= bt - 16'd1;
          else begin
            txd <= sh[0];
            bi <= '0;
            bt <= BT_MAX;
            state <= DATA;
          end
        DATA:
          if (bt != '0) bt <= bt - 16'd1;
          else begin
            bt <= BT_MAX;
            if (bi == 3'd7) begin
              txd <= 1'b1;
              state <= STOP;
            end else begin
              sh <= sh >> 1;
              txd <= sh[1];
              bi <= bi + 3'd1;
            end
          end
        STOP:
          if (bt != '0) bt <= bt - 16'd1;
          else if (pop) begin
            sh <= mem[rp];
            txd <= 1'b0;
            bt <= BT_MAX;
            state <= START;
          end else state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_m_uart_tx.sv
// tb_m_uart_tx: directed and random bus traffic checked cycle by cycle against
// a queue-and-frame-position model of the transmitter.
module tb_m_uart_tx;
  localparam int CD = 4;
  localparam int FRAME = 10 * CD;
  logic clk = 1'b0;
  logic RST_I, STB_I, WE_I, ADR_I;
  logic [7:0] DAT_I, DAT_O;
  logic ACK_O, txd;
  int checks = 0, errors = 0;
  logic [7:0] rd;
  logic [7:0] m_q[$];
  bit m_active, m_ovf;
  int m_pos;
  logic [7:0] m_cur;

  m_uart_tx #(.CLKDIV(CD), .FIFOLOG2(3)) dut (
    .CLK_I(clk), .RST_I(RST_I), .STB_I(STB_I), .WE_I(WE_I), .ADR_I(ADR_I),
    .DAT_I(DAT_I), .ACK_O(ACK_O), .DAT_O(DAT_O), .txd(txd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic exp_txd();
    int k;
    if (!m_active) return 1'b1;
    k = m_pos / CD;
    if (k == 0) return 1'b0;
    if (k <= 8) return m_cur[k-1];
    return 1'b1;
  endfunction

  function automatic logic [7:0] exp_status();
    int n;
    n = m_q.size();
    return {4'(n), m_ovf, m_active, n == 8, n == 0};
  endfunction

  function automatic void model_reset();
    m_q.delete();
    m_active = 0;
    m_ovf = 0;
    m_pos = 0;
  endfunction

  // frame advances first (using the pre-edge queue), then the bus write lands
  function automatic void model_step(input logic stb, we, adr, input logic [7:0] d);
    if (m_active && m_pos < FRAME - 1) m_pos++;
    else if (m_q.size() > 0) begin
      m_cur = m_q.pop_front();
      m_active = 1;
      m_pos = 0;
    end else m_active = 0;
    if (stb && we && !adr) begin
      if (m_q.size() < 8) m_q.push_back(d);
      else m_ovf = 1;
    end
    if (stb && we && adr && d[0]) m_ovf = 0;
  endfunction

  task automatic cycle(input logic stb, we, adr, input logic [7:0] d);
    @(negedge clk);
    STB_I = stb;
    WE_I = we;
    ADR_I = adr;
    DAT_I = d;
    #1;
    rd = DAT_O;
    chk("txd", 8'(txd), 8'(exp_txd()));
    chk("ack", 8'(ACK_O), 8'(stb));
    chk("dat", DAT_O, (stb && !we && !adr) ? exp_status() : 8'h00);
    @(posedge clk);
    model_step(stb, we, adr, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 8'h00);
  endtask

  task automatic async_reset();
    @(negedge clk);
    STB_I = 0;
    WE_I = 0;
    ADR_I = 0;
    #2;
    RST_I = 1;
    #1;
    chk("rst_txd", 8'(txd), 8'h01);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    RST_I = 0;
  endtask

  initial begin
    int guard;
    RST_I = 1;
    STB_I = 0;
    WE_I = 0;
    ADR_I = 0;
    DAT_I = 0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    RST_I = 0;
    // reset and idle
    idle(20);
    cycle(1, 0, 0, 8'h00);
    chk("reset_status", rd, 8'h01);
    cycle(1, 0, 1, 8'h00);
    chk("ctrl_read", rd, 8'h00);
    // single frame
    cycle(1, 1, 0, 8'hA5);
    idle(FRAME + 2);
    cycle(1, 0, 0, 8'h00);
    chk("after_a5", rd, 8'h01);
    // nine consecutive bytes
    for (int i = 0; i < 9; i++) cycle(1, 1, 0, 8'(i));
    cycle(1, 0, 0, 8'h00);
    chk("nine_status", rd, 8'h86);
    idle(9 * FRAME + 4);
    cycle(1, 0, 0, 8'h00);
    chk("nine_drained", rd, 8'h01);
    // overflow and clear
    for (int i = 0; i < 9; i++) cycle(1, 1, 0, 8'h10 + 8'(i));
    cycle(1, 1, 0, 8'hFF);
    cycle(1, 0, 0, 8'h00);
    chk("ovf_status", rd, 8'h8E);
    cycle(1, 1, 1, 8'h01);
    cycle(1, 0, 0, 8'h00);
    chk("ovf_cleared", rd, 8'h86);
    idle(9 * FRAME + 4);
    // async reset mid DATA
    cycle(1, 1, 0, 8'h55);
    idle(3 * CD);
    async_reset();
    cycle(1, 0, 0, 8'h00);
    chk("rst_status", rd, 8'h01);
    idle(FRAME + 4);
    // push into full FIFO on the pop edge
    for (int i = 0; i < 9; i++) cycle(1, 1, 0, 8'h20 + 8'(i));
    guard = 0;
    while (!(m_active && m_pos == FRAME - 1 && m_q.size() == 8) && guard < 200) begin
      cycle(0, 0, 0, 8'h00);
      guard++;
    end
    chk("pop_edge_found", 8'(guard < 200), 8'h01);
    cycle(1, 1, 0, 8'hC3);
    cycle(1, 0, 0, 8'h00);
    chk("simul_status", rd, 8'h86);
    idle(9 * FRAME + 4);
    // random traffic
    for (int i = 0; i < 4000; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if ($urandom_range(0, 1499) == 0) async_reset();
      else if (r < 8) cycle(1, 1, 0, 8'($urandom));
      else if (r < 10) cycle(1, 1, 1, 8'($urandom));
      else if (r < 25) cycle(1, 0, 0, 8'($urandom));
      else if (r < 28) cycle(1, 0, 1, 8'($urandom));
      else if (r < 30) cycle(0, 1, 0, 8'($urandom));
      else cycle(0, 0, 0, 8'h00);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/m_uart_tx.md
# m_uart_tx

Wishbone-attached UART transmitter with an 8-entry byte FIFO, a slave on the midgetv core bus next to the LED, digilent and FM-transmitter peripherals. The core pushes bytes faster than the line can drain them, and the block serialises them 8N1, LSB first, onto a board pad. A read-side status register lets firmware poll FIFO level and overflow without stalling the bus.

## Interface
Parameters:
- CLKDIV, 286: clock cycles per bit. 33 MHz / 115200 baud rounds to 286. Legal range 2..65535.
- FIFOLOG2, 3: log2 of the FIFO depth. Default depth 8.

Ports:
- CLK_I  input  1  system clock. Every register is updated on the rising edge.
- RST_I  input  1  reset, asynchronous, active-high.
- STB_I  input  1  Wishbone strobe. Already qualified with the address decode by the interconnect.
- WE_I  input  1  write enable.
- ADR_I  input  1  register select: 0 = DATA/STATUS, 1 = CONTROL.
- DAT_I  input  8  write data.
- ACK_O  output  1  Wishbone acknowledge. ACK_O = STB_I, combinational.
- DAT_O  output  8  read data. Forced to 0 unless STB_I & ~WE_I, so the interconnect can OR it onto the bus.
- txd  output  1  serial line. Registered. Idle high.

## Operation
- Register map, write side:
  - ADR_I=0: push DAT_I into the FIFO. If the FIFO is full, the byte is dropped and the sticky `ovf` flag is set.
  - ADR_I=1: a write with DAT_I[0]=1 clears `ovf`. All other bits are ignored.
- Register map, read side:
  - ADR_I=0 reads STATUS = {count[3:0], ovf, busy, full, empty}, MSB first.
  - `count` is the number of entries, 0..2^FIFOLOG2. For FIFOLOG2 > 3 it saturates at 15 in this field.
  - `busy` = state != IDLE.
  - ADR_I=1 reads 0.
- FIFO structure: circular buffer with read pointer, write pointer and a count register of width FIFOLOG2+1. The pointers wrap modulo 2^FIFOLOG2.
- Simultaneous push and pop:
  - With the FIFO full, the push is accepted. `count` stays at full, `ovf` is not set.
  - With the FIFO empty, no pop can occur, so the push simply lands.
- Transmit FSM states: IDLE, START, DATA, STOP. Supporting registers: bit-timer `bt`, counting CLKDIV-1 down to 0; bit index `bi`, 0..7; shift register `sh`, 8 bits.
  - IDLE: if the FIFO is not empty, pop its head into `sh`, set txd<=0, bt<=CLKDIV-1, go to START. Otherwise hold txd<=1.
  - START: while bt>0, decrement bt. When bt==0: txd<=sh[0], bi<=0, bt<=CLKDIV-1, go to DATA.
  - DATA: when bt==0:
    - If bi==7: txd<=1, go to STOP.
    - Otherwise: shift sh right, txd<=next bit, bi<=bi+1.
    - In both cases bt<=CLKDIV-1.
  - STOP: when bt==0:
    - If the FIFO is not empty, pop immediately: txd<=0, go to START. There is no extra idle cycle.
    - Otherwise go to IDLE.
- Reset, asynchronous. It is honoured mid-frame: the frame is abandoned and the line returns high at once. Reset values:
  - FIFO: empty, pointers 0, count 0.
  - ovf=0, state=IDLE, bt=0, bi=0, sh=0.
  - txd=1.
  - ACK_O and DAT_O follow their combinational definitions, so they are 0 while STB_I=0.

## Timing
- Bus accesses complete in one cycle with zero wait states.
- A push takes effect on the edge where STB_I&WE_I&~ADR_I=1. STATUS reads in the following cycle reflect it.
- Pop happens on the edge where the FSM leaves IDLE or STOP. It is visible in `count` in the next cycle.
- Latency from the push edge into an empty, idle block to the txd falling edge: one clock. The start bit is driven from the edge after the push.
- Every bit, including start and stop, lasts exactly CLKDIV cycles.
- Frame length: 10*CLKDIV cycles. Back-to-back frames are contiguous.
- `busy` falls CLKDIV cycles after the stop bit begins, and only if the FIFO is empty at that point.

## Test plan
All scenarios use CLKDIV=4 and FIFOLOG2=3.
- Reset, then idle 20 cycles -> txd=1 throughout; STATUS read = 0x01; ACK_O is 0 whenever STB_I=0.
- Write 0xA5 -> txd low starting one clock after the write edge, then bits 1,0,1,0,0,1,0,1 (LSB first), then stop high. Each bit lasts 4 cycles; the frame lasts 40 cycles. STATUS returns to 0x01 afterward.
- Write 9 bytes 0x00..0x08 in consecutive cycles. Expected response:
  - The first byte is popped after one cycle.
  - The remaining 8 fill the FIFO: STATUS = 0x86 (count=8, busy, full).
  - All 9 frames are serialised contiguously in order; no ovf.
- Fill the FIFO while the first frame is in flight, then write 0xFF -> byte dropped, STATUS bit3=1. Write 1 to ADR 1 -> ovf=0. Exactly 9 frames appear, with no 0xFF.
- Write 0x55 and assert RST_I asynchronously in the middle of DATA -> txd=1 immediately, STATUS=0x01, no further frame.
- Push into a full FIFO on the same edge the FSM pops -> byte accepted, count stays 8, ovf stays 0. The final frame carries that byte.
